// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_mdu execute unit.
//   - 5-bit opcodes {M, funct7[5], funct3}. For M ops only the low three bits
//     select the operation.
//   - FSM state encoding.
//   - Divide-corner constants, built as functions of the operand width.
package alu_pkg;

  // Base integer operations (M = 0)
  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b01000;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b00111;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b01101;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b00011;

  // Multiply / divide operations (M = 1, bit 3 is don't-care)
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the corner-constant helpers can describe.
  localparam int MAX_WIDTH = 64;

  // Most-negative two's-complement value of a w-bit word.
  function automatic logic [MAX_WIDTH-1:0] most_neg(input int unsigned w);
    most_neg = MAX_WIDTH'(1) << (w - 1);
  endfunction

  // All-ones w-bit word (-1 signed, divide-by-zero quotient).
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned w);
    all_ones = (MAX_WIDTH'(1) << w) - MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 engine for the alu_mdu unit.
//   Unsigned shift-add multiplier and (when ALU_MDU_DIV_EN is defined)
//   restoring divider, both sharing one WIDTH+1 adder. Operands arrive as
//   magnitudes; sign handling lives in the top level.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load operands a/b and clear the accumulator
//   start_div     (ALU_MDU_DIV_EN only) operation loaded at start is a divide
//   step          perform one iteration
//   a, b          multiply: multiplicand a, multiplier b
//                 divide:   dividend a, divisor b
//   hi_nxt        value the high register takes on this step
//                 (product high half / remainder after the last step)
//   lo_nxt        value the low register takes on this step
//                 (product low half / quotient after the last step)
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_MDU_DIV_EN
  input  logic             start_div,
`endif
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH:0]   add_sum;
  logic             add_cin;

`ifdef ALU_MDU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   shifted;

  // Partial remainder with the next dividend bit shifted in.
  assign shifted = {hi, lo[WIDTH-1]};
`endif

  assign add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

  always_comb begin
    add_a   = {1'b0, hi};
    add_b   = {1'b0, m};
    add_cin = 1'b0;
`ifdef ALU_MDU_DIV_EN
    if (div_q) begin
      // shifted - divisor; since shifted < 2*divisor, bit WIDTH of the
      // difference is set exactly when the subtraction borrowed.
      add_a   = shifted;
      add_b   = ~{1'b0, m};
      add_cin = 1'b1;
    end
`endif
  end

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
`ifdef ALU_MDU_DIV_EN
    if (div_q) begin
      hi_nxt = add_sum[WIDTH] ? shifted[WIDTH-1:0] : add_sum[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ~add_sum[WIDTH]};
    end else
`endif
    begin
      // Add the multiplicand when the current multiplier bit is set, then
      // shift the whole {hi, lo} product register right by one.
      if (lo[0]) begin
        hi_nxt = add_sum[WIDTH:1];
        lo_nxt = {add_sum[0], lo[WIDTH-1:1]};
      end else begin
        hi_nxt = {1'b0, hi[WIDTH-1:1]};
        lo_nxt = {hi[0], lo[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
`ifdef ALU_MDU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      hi    <= '0;
`ifdef ALU_MDU_DIV_EN
      div_q <= start_div;
      lo    <= start_div ? a : b;
      m     <= start_div ? b : a;
`else
      lo    <= b;
      m     <= a;
`endif
    end else if (step) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked RV32I ALU plus M-extension multiply/divide.
//   Base ops complete in one cycle; M ops run WIDTH iterations in mdu_iter.
//   Optional feature macro: ALU_MDU_DIV_EN builds the divider. Without it,
//   DIV/DIVU/REM/REMU behave as undefined base ops (1 cycle, result 0).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   inValid / inReady   operation handshake (A1, A2, aluCont)
//   A1, A2              operands
//   aluCont             opcode {M, funct7[5], funct3}
//   outValid / outReady result handshake (aluOut)
//   aluOut              registered result
//   dbg_state           current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps data stable while valid is high and not yet
// accepted; ready never depends on the same-cycle valid of the other side.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [4:0]       aluCont,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] aluOut,
  output state_t           dbg_state
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [SHW-1:0]     cnt;
  logic               accept;
  logic               is_mop;
  logic               signed_a, signed_b, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   base_res, mdu_res;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [2:0]         op_q;
  logic               a_neg_q, b_neg_q;

`ifdef ALU_MDU_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));
  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));
  logic [WIDTH-1:0] a_q, b_q;
  logic             div_zero, div_ovf;

  assign is_mop   = aluCont[4];
  assign div_zero = (b_q == '0);
  assign div_ovf  = (a_q == MOST_NEG) && (b_q == ALL_ONES);
`else
  // Divide opcodes fall through to the base path and return 0.
  assign is_mop   = aluCont[4] && !aluCont[2];
`endif

  assign accept    = inValid && inReady;
  assign dbg_state = state;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) state_nxt = is_mop ? EXEC : DONE;
      end
      EXEC: if (cnt == CNT_LAST) state_nxt = DONE;
      DONE: begin
        outValid = 1'b1;
        if (outReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- Base ALU (evaluated on the accept cycle) ----------------
  always_comb begin
    case (aluCont)
      OP_ADD:  base_res = A1 + A2;
      OP_SUB:  base_res = A1 - A2;
      OP_XOR:  base_res = A1 ^ A2;
      OP_OR:   base_res = A1 | A2;
      OP_AND:  base_res = A1 & A2;
      OP_SLL:  base_res = A1 << A2[SHW-1:0];
      OP_SRL:  base_res = A1 >> A2[SHW-1:0];
      OP_SRA:  base_res = $signed(A1) >>> A2[SHW-1:0];
      OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(A1) < $signed(A2))};
      OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, (A1 < A2)};
      default: base_res = '0;
    endcase
  end

  // ---------------- Operand conditioning for mdu_iter ----------------
  assign signed_a = (aluCont[2:0] == OP_MULH[2:0]) || (aluCont[2:0] == OP_MULHSU[2:0]) ||
                    (aluCont[2:0] == OP_DIV[2:0])  || (aluCont[2:0] == OP_REM[2:0]);
  assign signed_b = (aluCont[2:0] == OP_MULH[2:0]) ||
                    (aluCont[2:0] == OP_DIV[2:0])  || (aluCont[2:0] == OP_REM[2:0]);
  assign a_neg    = signed_a && A1[WIDTH-1];
  assign b_neg    = signed_b && A2[WIDTH-1];
  assign a_mag    = a_neg ? -A1 : A1;
  assign b_mag    = b_neg ? -A2 : A2;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && is_mop),
`ifdef ALU_MDU_DIV_EN
    .start_div(aluCont[2]),
`endif
    .step     (state == EXEC),
    .a        (a_mag),
    .b        (b_mag),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt)
  );

  // ---------------- Sign fix-up on the final iteration ----------------
  // MUL never sets the sign flags, so its low half comes straight through.
  assign prod     = {hi_nxt, lo_nxt};
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;

  always_comb begin
    mdu_res = '0;
    case (op_q)
      OP_MUL[2:0]:    mdu_res = prod_fix[WIDTH-1:0];
      OP_MULH[2:0],
      OP_MULHSU[2:0],
      OP_MULHU[2:0]:  mdu_res = prod_fix[2*WIDTH-1:WIDTH];
`ifdef ALU_MDU_DIV_EN
      OP_DIV[2:0]: begin
        if (div_zero)     mdu_res = '1;
        else if (div_ovf) mdu_res = MOST_NEG;
        else              mdu_res = (a_neg_q ^ b_neg_q) ? -lo_nxt : lo_nxt;
      end
      OP_DIVU[2:0]:   mdu_res = div_zero ? '1 : lo_nxt;
      OP_REM[2:0]: begin
        if (div_zero)     mdu_res = a_q;
        else if (div_ovf) mdu_res = '0;
        else              mdu_res = a_neg_q ? -hi_nxt : hi_nxt;  // sign of dividend
      end
      OP_REMU[2:0]:   mdu_res = div_zero ? a_q : hi_nxt;
`endif
      default:        mdu_res = '0;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluOut  <= '0;
      cnt     <= '0;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      a_q     <= '0;
      b_q     <= '0;
`endif
    end else if (accept) begin
      cnt <= '0;
      if (is_mop) begin
        op_q    <= aluCont[2:0];
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
`ifdef ALU_MDU_DIV_EN
        a_q     <= A1;
        b_q     <= A2;
`endif
      end else begin
        aluOut <= base_res;
      end
    end else if (state == EXEC) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) aluOut <= mdu_res;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu (WIDTH = 32).
//   Directed cases for the documented corners, then randomized operations
//   checked against an arithmetic reference model built on 64-bit integers.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] a2 = '0;
  logic [4:0]   alu_cont = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  state_t       dbg_state;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .A1       (a1),
    .A2       (a2),
    .aluCont  (alu_cont),
    .outValid (out_valid),
    .outReady (out_ready),
    .aluOut   (alu_out),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  logic [4:0] op_tab [0:17] = '{
    5'b00000, 5'b01000, 5'b00100, 5'b00110, 5'b00111, 5'b00001, 5'b00101,
    5'b01101, 5'b00010, 5'b00011, 5'b10000, 5'b10001, 5'b10010, 5'b10011,
    5'b10100, 5'b10101, 5'b10110, 5'b11111};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit div_built();
`ifdef ALU_MDU_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit takes_iter(input logic [4:0] op);
    return op[4] && (div_built() || !op[2]);
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [4:0]      sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    sh = b[4:0];
    if (op[4]) begin
      case (op[2:0])
        3'd0: return W'(ua * ub);
        3'd1: return W'((sa * sb) >>> W);
        3'd2: return W'((sa * longint'(ub)) >>> W);
        3'd3: return W'((ua * ub) >> W);
        default: ;
      endcase
      if (!div_built()) return '0;
      case (op[2:0])
        3'd4: begin
          if (b == 0) return '1;
          if (a == MIN_NEG && b == '1) return MIN_NEG;
          return W'(sa / sb);
        end
        3'd5: return (b == 0) ? '1 : W'(ua / ub);
        3'd6: begin
          if (b == 0) return a;
          if (a == MIN_NEG && b == '1) return '0;
          return W'(sa % sb);
        end
        default: return (b == 0) ? a : W'(ua % ub);
      endcase
    end
    case (op[3:0])
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return W'(sa >>> sh);
      4'b0010: return (sa < sb) ? 1 : 0;
      4'b0011: return (ua < ub) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return MIN_NEG;
      4: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- driver ----------------
  // Entered and left on a negedge. stall = cycles outReady is held low in DONE.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    int           lat;
    int           exp_lat;
    logic [W-1:0] exp;
    lat = 0;
    while (!in_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("ready_before", in_ready, 1);
    exp_q.push_back(ref_alu(op, a, b));
    exp_lat = takes_iter(op) ? W + 1 : 1;
    alu_cont = op;
    a1 = a;
    a2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs: the unit must work from its captured copy.
    in_valid = 1'b0;
    a1 = $urandom;
    a2 = $urandom;
    alu_cont = 5'($urandom);
    check("busy_after_accept", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < W + 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_op%02h", op), lat, exp_lat);
    exp = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_busy", in_ready, 0);
      check("hold_data", alu_out, exp);
      @(negedge clk);
    end
    check($sformatf("result_op%02h a=%h b=%h", op, a, b), alu_out, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_consume", {out_valid, in_ready}, 2'b01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_out", alu_out, 0);
    check("rst_state", dbg_state, IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ADD back-to-back with outReady held high
    a1 = 7; a2 = 5; alu_cont = OP_ADD; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_valid", out_valid, 1);
    check("b2b_sum", alu_out, 12);
    check("b2b_busy", in_ready, 0);
    a1 = 1; a2 = 2;
    @(negedge clk);
    check("b2b_gap", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    check("b2b_second_valid", out_valid, 1);
    check("b2b_second_sum", alu_out, 3);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", {out_valid, in_ready}, 2'b01);

    // Reset in the middle of a multiply
    a1 = 32'h1234_5678; a2 = 32'h9abc_def0; alu_cont = OP_MUL; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_exec_state", dbg_state, EXEC);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_out", alu_out, 0);
    check("mid_rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", in_ready, 1);
    run_op(OP_ADD, 32'd100, 32'd23, 0);

    // Shifts and compares
    run_op(OP_SRA, 32'h8000_0000, 32'h0000_0024, 0);
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(OP_SLL, 32'h0000_0003, 32'hFFFF_FFE1, 0);
    run_op(5'b01111, 32'h1111_1111, 32'h2222_2222, 0);

    // Multiply corners
    run_op(OP_MUL, '1, '1, 0);
    run_op(OP_MULH, '1, '1, 0);
    run_op(OP_MULHU, '1, '1, 0);
    run_op(OP_MULHSU, '1, '1, 0);
    run_op(5'b11001, MIN_NEG, MIN_NEG, 0);

    // Divide corners (model returns 0 / 1-cycle when the divider is absent)
    run_op(OP_DIV, MIN_NEG, '1, 0);
    run_op(OP_REM, MIN_NEG, '1, 0);
    run_op(OP_DIVU, 32'd5, 32'd0, 0);
    run_op(OP_REMU, 32'd5, 32'd0, 0);
    run_op(OP_DIV, -32'sd7, 32'd2, 0);
    run_op(OP_REM, -32'sd7, 32'd2, 0);
    run_op(OP_DIV, -32'sd7, 32'd0, 0);
    run_op(OP_REM, 32'd100, -32'sd7, 0);

    // Backpressure: result held for 10 cycles
    run_op(OP_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10);
    run_op(OP_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 10);

    // Randomized operations
    for (int n = 0; n < 80; n++) begin
      logic [4:0] op;
      if ($urandom_range(0, 3) == 0) op = 5'($urandom);
      else op = op_tab[$urandom_range(0, 17)];
      run_op(op, pick_operand(), pick_operand(), $urandom_range(0, 3));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked successor to the single-cycle RV32I ALU. It executes all base integer ALU operations, adding the signed SLT that the old ALU lacked, plus the RV M-extension multiply/divide operations. Base operations take one cycle; M operations use an iterative radix-2 engine. It sits in the execute stage and stalls the pipeline through valid/ready handshakes.

## Interface
- `WIDTH`, 32: operand and result width, ≥ 8, power of two.
- `SHW`, $clog2(WIDTH): shift-amount width, derived; not to be overridden.

- `clk`: in, 1. Rising-edge clock.
- `rst`: in, 1. Reset, **asynchronous, active-high**.
- `inValid`: in, 1. Operands and opcode are valid.
- `inReady`: out, 1. Unit can accept an operation.
- `A1`: in, WIDTH. Operand 1 (rs1 or PC).
- `A2`: in, WIDTH. Operand 2 (rs2 or immediate).
- `aluCont`: in, 5. Opcode = {M, funct7[5], funct3}. Bit 3 is ignored when M=1.
- `outValid`: out, 1. `aluOut` holds a result.
- `outReady`: in, 1. Consumer accepts the result.
- `aluOut`: out, WIDTH. Result, registered.

## Operation
- **Base opcodes (M=0):**
  - 0_0000 ADD; 0_1000 SUB; 0_0100 XOR; 0_0110 OR; 0_0111 AND.
  - 0_0001 SLL; 0_0101 SRL; 0_1101 SRA (arithmetic).
  - 0_0010 SLT (signed); 0_0011 SLTU.
- **M opcodes (M=1, low 3 bits):**
  - 000 MUL (low half); 001 MULH (s×s); 010 MULHSU (s×u); 011 MULHU (u×u).
  - 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- **Shifts:** shift amount is `A2[SHW-1:0]`. Upper bits of A2 are ignored.
- **Arithmetic width:** all results are truncated to WIDTH (modular). SLT/SLTU return 1 or 0, zero-extended.
- **Undefined base opcodes:** accepted and complete normally with result 0.
- **Divide corner cases (RISC-V rules):**
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed most-negative / −1: quotient = most-negative; remainder = 0.
  - These do not shorten latency.
- **Signed divide:** operands are converted to magnitude before iterating. Signs are applied at completion. Remainder takes the sign of the dividend.
- **FSM:**
  - IDLE → EXEC on accept with an M op.
  - IDLE → DONE on accept with a base op.
  - EXEC → DONE when the iteration counter reaches WIDTH−1.
  - DONE → IDLE on `outValid && outReady`.
- **Accept condition:** `inValid && inReady`. Operands and opcode are captured at accept, so later changes on the inputs have no effect.
- **Outputs by state:**
  - `inReady` = 1 only in IDLE.
  - `outValid` = 1 only in DONE.
- **Backpressure:** `aluOut` is held stable in DONE until the result is consumed.
- **Reset:**
  - Values: state IDLE, `inReady` 1, `outValid` 0, `aluOut` 0, counter 0.
  - Reset mid-operation discards the in-flight operation immediately.
  - Reset has priority over every other event.

## Timing
- Accept at edge t:
  - Base op: `outValid` rises after edge t+1.
  - M op: `outValid` rises after edge t+WIDTH+1 (33 cycles for WIDTH=32).
- **Fixed latency:** all M-op latencies are fixed, with no early termination.
- **Throughput:** no overlap between operations. Minimum spacing between accepts is 2 cycles for base ops and WIDTH+2 cycles for M ops.
- **Same-cycle handshake:** consume in DONE and a new `inValid` in the same cycle do not overlap. The new op is accepted on the following cycle, when the unit is back in IDLE.

## Configuration
- **Macro:** `ALU_MDU_DIV_EN`.
- **Defined:** DIV/DIVU/REM/REMU execute as above.
- **Undefined:**
  - The divider datapath is not built.
  - Divide opcodes take the base-op path: 1-cycle latency, result 0.
  - Multiply is always present.

## Structure
- **Package `alu_pkg`:**
  - Opcode localparams for all 5-bit codes.
  - State enum {IDLE, EXEC, DONE}.
  - Divide-corner constants as functions of WIDTH.
- **Sub-module `mdu_iter`:** radix-2 shift-add multiplier and restoring divider, sharing one WIDTH+1 adder. It is controlled by the top FSM through start/op/count. The top level holds operand capture, base ALU, sign fix-up and handshake.

## Test plan
- **ADD, back-to-back:** ADD 7+5 accepted at t → `aluOut`=12, `outValid` at t+1; `inReady` low at t+1; next accept no earlier than t+2.
- **Shifts and compares:**
  - SRA 0x80000000 by A2=0x24 (amount 4) → 0xF8000000.
  - SLT(0xFFFFFFFF, 1) → 1; SLTU of the same operands → 0.
- **Multiply (WIDTH=32):** A1=A2=0xFFFFFFFF:
  - MUL → 1; MULH → 0; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
  - Each with `outValid` exactly 33 cycles after accept.
- **Divide corners (with `ALU_MDU_DIV_EN`):**
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - Without the macro, DIV → 0 after 1 cycle.
- **Backpressure:** hold `outReady`=0 for 10 cycles in DONE → `aluOut` stable, `inReady` 0; release → one handshake, then IDLE.
- **Reset mid-multiply:** assert `rst` at EXEC iteration 10 → `outValid` 0, `aluOut` 0 asynchronously; after release, `inReady` 1 and a fresh ADD completes correctly.
